vga_layer_compositor: RTL
=========================

Name: vga_layer_compositor

Overview:
- Parametrised compositing stage for the VGA pixel pipeline.
- Sits after vga_timing and draw_bg, in place of a fixed chain of single-object draw stages.
- Merges N_LAYERS sprite/overlay pixel streams onto the background stream using fixed priority and colour-key transparency.
- Layer enables are double-buffered so changes take effect only at frame boundaries (no tearing); the block also emits a frame tick and a frame counter for game logic.

Parameters:
- N_LAYERS, 4: number of overlay layers, 1..8; index N_LAYERS-1 has highest priority.
- PIPE_DEPTH, 2: total latency in clk cycles from input to output, >= 1.
- KEY_EN, 1: 1 = layer pixel equal to KEY_COLOR is transparent.
- KEY_COLOR, 12'hF0F: transparent colour key.
- EN_RESET, all ones (N_LAYERS bits): active layer-enable mask after reset.
- FCNT_W, 16: frame counter width.

Ports:
- clk  in  1  pixel clock
- rst  in  1  synchronous, active-high reset
- in_hcount  in  11  horizontal position from upstream vga_if
- in_vcount  in  11  vertical position
- in_hsync  in  1  horizontal sync
- in_vsync  in  1  vertical sync
- in_hblnk  in  1  horizontal blank
- in_vblnk  in  1  vertical blank
- in_rgb  in  12  background pixel {r,g,b}
- layer_rgb  in  12*N_LAYERS  layer pixels; layer i = bits [12*i+11:12*i]; aligned with in_* signals
- layer_valid  in  N_LAYERS  layer i covers the current pixel
- layer_en_req  in  N_LAYERS  requested enable mask; sampled at frame boundary
- out_hcount, out_vcount  out  11 each  delayed copies of the inputs
- out_hsync, out_vsync, out_hblnk, out_vblnk  out  1 each  delayed copies of the inputs
- out_rgb  out  12  composited pixel
- layer_en_act  out  N_LAYERS  mask currently in effect
- frame_tick  out  1  one-cycle pulse at frame boundary
- frame_cnt  out  FCNT_W  frames since reset

Behaviour:
- Frame boundary: cycle where in_vblnk = 1 and the registered previous in_vblnk = 0 (rising edge).
- Active mask update:
  - At a frame boundary, layer_en_act <= layer_en_req, using the value present in that same cycle.
  - layer_en_act holds its value at all other times.
  - A req change in the same cycle as the boundary is taken; a change one cycle later waits for the next frame.
- frame_tick: 1 in the cycle after the boundary, 0 otherwise.
- frame_cnt: increments on the same edge frame_tick rises; wraps from 2^FCNT_W-1 to 0 with no flag.
- Composition (stage 1, combinational on registered inputs):
  - Layer i is opaque iff layer_valid[i] & layer_en_act[i] & !(KEY_EN & layer_rgb_i == KEY_COLOR).
  - Result = rgb of the highest-index opaque layer; if no layer is opaque, in_rgb.
  - If hblnk | vblnk, result = 12'h000 regardless of layers.
- Latency:
  - All out_* signals equal the in_* signals / composite delayed exactly PIPE_DEPTH cycles.
  - Sync, blank and counts go through the same delay line as rgb, so they stay aligned.
  - Stages beyond the first are pure delay.
- Mask usage: the mask applied to a pixel is the layer_en_act value in the cycle that pixel is registered into stage 1.
- Reset:
  - While rst = 1, every pipeline register and every output is cleared: out_* = 0, out_rgb = 0, frame_tick = 0, frame_cnt = 0, layer_en_act = EN_RESET, previous-vblnk register = 0.
  - Asserting rst mid-frame flushes the pipeline.
  - After release, out_* show zeros for PIPE_DEPTH cycles, then track the inputs.
  - If in_vblnk = 1 in the first cycle after reset, that cycle counts as a frame boundary.
- No backpressure: the stream is free-running, one pixel per clk.

Decomposition:
- vga_pkg holds:
  - Constants: HCOUNT_W = 11, RGB_W = 12, BLACK = 12'h000, DEFAULT_KEY = 12'hF0F.
  - Typedefs: rgb_t (logic [RGB_W-1:0]) and vga_sig_t (packed struct of hcount, vcount, hsync, vsync, hblnk, vblnk, rgb).
- Sub-module: vga_delay_line, parameters WIDTH and DEPTH; a synchronous shift register with rst clear. It is instantiated once for the packed vga_sig_t stages 2..PIPE_DEPTH.

Test Plan:
1. Priority. Defaults, active pixel, in_rgb = 12'h123, layers 1 and 3 valid with rgb 12'h0A0 and 12'hB00, mask 4'hF → out_rgb = 12'hB00 exactly 2 cycles later.
2. Colour key. Layer 3 rgb = 12'hF0F, layer 1 rgb = 12'h0A0, both valid → out_rgb = 12'h0A0. Same stimulus with KEY_EN = 0 → 12'hF0F.
3. Blanking. in_hblnk = 1, in_rgb = 12'hFFF, layer 0 valid with 12'h00F → out_rgb = 12'h000. Syncs and counts are delayed by 2 and otherwise unchanged.
4. Tear-free mask update:
   - Change layer_en_req from 4'hF to 4'h0 mid-frame → layer_en_act stays 4'hF and layer pixels keep showing until the vblnk rising edge.
   - Then layer_en_act = 4'h0; frame_tick pulses for one cycle and frame_cnt goes 0 → 1.
   - A req change 1 cycle after the edge is deferred by a full frame.
5. Counter wrap. FCNT_W = 2, run 5 frame boundaries → frame_cnt goes 1, 2, 3, 0, 1.
6. Reset mid-frame. Assert rst during an active line with PIPE_DEPTH = 4:
   - All outputs read 0 and layer_en_act = EN_RESET.
   - After release, out_rgb = 0 for 4 cycles, then follows the input pattern delayed by 4.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared widths, colours and the packed pixel-stream record used by the VGA compositing path.
package vga_pkg;

    localparam int HCOUNT_W = 11;
    localparam int RGB_W    = 12;

    localparam logic [RGB_W-1:0] BLACK       = 12'h000;
    localparam logic [RGB_W-1:0] DEFAULT_KEY = 12'hF0F;

    typedef logic [RGB_W-1:0] rgb_t;

    typedef struct packed {
        logic [HCOUNT_W-1:0] hcount;
        logic [HCOUNT_W-1:0] vcount;
        logic                hsync;
        logic                vsync;
        logic                hblnk;
        logic                vblnk;
        rgb_t                rgb;
    } vga_sig_t;

endpackage

// File: rtl/vga_delay_line.sv
// Plain shift register of DEPTH stages; every stage clears while rst is held.
module vga_delay_line #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] stage_q [DEPTH];
    logic [WIDTH-1:0] stage_d [DEPTH];

    always_comb begin
        stage_d[0] = din;
        for (int i = 1; i < DEPTH; i++) begin
            stage_d[i] = stage_q[i-1];
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (rst) begin
                stage_q[i] <= '0;
            end else begin
                stage_q[i] <= stage_d[i];
            end
        end
    end

    assign dout = stage_q[DEPTH-1];

endmodule

// File: rtl/vga_layer_compositor.sv
// Merges N_LAYERS colour-keyed overlay streams onto the background stream, with the
// layer-enable mask swapped only at the vblank rising edge to avoid tearing.
module vga_layer_compositor
    import vga_pkg::*;
#(
    parameter int                N_LAYERS   = 4,
    parameter int                PIPE_DEPTH = 2,
    parameter int                KEY_EN     = 1,
    parameter logic [11:0]       KEY_COLOR  = DEFAULT_KEY,
    parameter logic [N_LAYERS-1:0] EN_RESET = '1,
    parameter int                FCNT_W     = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [10:0]             in_hcount,
    input  logic [10:0]             in_vcount,
    input  logic                    in_hsync,
    input  logic                    in_vsync,
    input  logic                    in_hblnk,
    input  logic                    in_vblnk,
    input  logic [11:0]             in_rgb,
    input  logic [12*N_LAYERS-1:0]  layer_rgb,
    input  logic [N_LAYERS-1:0]     layer_valid,
    input  logic [N_LAYERS-1:0]     layer_en_req,
    output logic [10:0]             out_hcount,
    output logic [10:0]             out_vcount,
    output logic                    out_hsync,
    output logic                    out_vsync,
    output logic                    out_hblnk,
    output logic                    out_vblnk,
    output logic [11:0]             out_rgb,
    output logic [N_LAYERS-1:0]     layer_en_act,
    output logic                    frame_tick,
    output logic [FCNT_W-1:0]       frame_cnt
);

    logic                vblnk_prev_q, vblnk_prev_d;
    logic [N_LAYERS-1:0] layer_en_act_q, layer_en_act_d;
    logic                frame_tick_q, frame_tick_d;
    logic [FCNT_W-1:0]   frame_cnt_q, frame_cnt_d;
    logic                frame_boundary;
    rgb_t                comp_rgb;
    vga_sig_t            stage1_q, stage1_d;
    vga_sig_t            out_sig;

    always_comb begin
        frame_boundary = in_vblnk & ~vblnk_prev_q;
        vblnk_prev_d   = in_vblnk;
        layer_en_act_d = frame_boundary ? layer_en_req : layer_en_act_q;
        frame_tick_d   = frame_boundary;
        frame_cnt_d    = frame_cnt_q + FCNT_W'(frame_boundary);
    end

    // Ascending scan so the highest-index opaque layer is the one left standing.
    always_comb begin
        comp_rgb = in_rgb;
        for (int i = 0; i < N_LAYERS; i++) begin
            if (layer_valid[i] && layer_en_act_q[i] &&
                !((KEY_EN != 0) && (layer_rgb[i*RGB_W +: RGB_W] == KEY_COLOR))) begin
                comp_rgb = layer_rgb[i*RGB_W +: RGB_W];
            end
        end
        if (in_hblnk || in_vblnk) begin
            comp_rgb = BLACK;
        end
        stage1_d = '{hcount: in_hcount, vcount: in_vcount,
                     hsync:  in_hsync,  vsync:  in_vsync,
                     hblnk:  in_hblnk,  vblnk:  in_vblnk,
                     rgb:    comp_rgb};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vblnk_prev_q   <= 1'b0;
            layer_en_act_q <= EN_RESET;
            frame_tick_q   <= 1'b0;
            frame_cnt_q    <= '0;
            stage1_q       <= '0;
        end else begin
            vblnk_prev_q   <= vblnk_prev_d;
            layer_en_act_q <= layer_en_act_d;
            frame_tick_q   <= frame_tick_d;
            frame_cnt_q    <= frame_cnt_d;
            stage1_q       <= stage1_d;
        end
    end

    // Everything after the compositing register is pure delay shared by syncs, counts and rgb.
    if (PIPE_DEPTH == 1) begin : g_no_delay
        assign out_sig = stage1_q;
    end else begin : g_delay
        vga_delay_line #(
            .WIDTH ($bits(vga_sig_t)),
            .DEPTH (PIPE_DEPTH - 1)
        ) u_delay (
            .clk  (clk),
            .rst  (rst),
            .din  (stage1_q),
            .dout (out_sig)
        );
    end

    assign out_hcount   = out_sig.hcount;
    assign out_vcount   = out_sig.vcount;
    assign out_hsync    = out_sig.hsync;
    assign out_vsync    = out_sig.vsync;
    assign out_hblnk    = out_sig.hblnk;
    assign out_vblnk    = out_sig.vblnk;
    assign out_rgb      = out_sig.rgb;
    assign layer_en_act = layer_en_act_q;
    assign frame_tick   = frame_tick_q;
    assign frame_cnt    = frame_cnt_q;

endmodule
